dsq_vec: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle distance-squared PCPI coprocessor. Decodes a custom-0 instruction, unpacks `LANES` element pairs from `rs1`, and serially accumulates per-lane squared or absolute differences into `rs2` or an internal accumulator. Sits on the PicoRV32 PCPI port beside the other custom units; results return through the standard `ready`/`wr`/`rd` handshake.

---
 rtl/dsq_pkg.sv | 27 ++
 rtl/dsq_lane.sv | 30 +++
 rtl/dsq_vec.sv | 173 +++++++++++++++++
 tb/tb_dsq_vec.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsq_pkg.sv
// dsq_vec shared definitions: decode constants, funct3 modes, FSM state
// encodings and the element-width/lane-count legality check.
package dsq_pkg;

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [6:0] F7_DSQ      = 7'b0000001;

    typedef enum logic [2:0] {
        MODE_SQ    = 3'b000,
        MODE_ABS   = 3'b001,
        MODE_SQACC = 3'b010,
        MODE_CLR   = 3'b011
    } mode_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Only the three packings of 32 bits that the decoder supports are legal.
    function automatic bit cfg_ok(input int elem_w, input int lanes);
        return (2 * elem_w * lanes == 32) &&
               ((elem_w == 8 && lanes == 2) ||
                (elem_w == 4 && lanes == 4) ||
                (elem_w == 16 && lanes == 1));
    endfunction

endpackage

// File: rtl/dsq_lane.sv
// dsq_lane: one element pair to a zero-extended accumulation term.
// Squared difference for SQ/SQACC, absolute difference for ABS.
module dsq_lane
    import dsq_pkg::*;
#(
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic [ELEM_W-1:0] x,
    input  logic [ELEM_W-1:0] xd,
    input  mode_e             mode,
    output logic [ACC_W-1:0]  term
);

    logic signed [ELEM_W:0]  diff;
    logic        [ELEM_W:0]  diff_u;
    logic        [ELEM_W-1:0] mag;
    logic      [2*ELEM_W-1:0] sq;

    // Magnitude of the one-bit-wider signed difference always fits in ELEM_W,
    // so squaring the magnitude gives the unsigned 2*ELEM_W-bit square.
    always_comb begin
        diff   = $signed({1'b0, x}) - $signed({1'b0, xd});
        diff_u = diff;
        mag    = diff_u[ELEM_W] ? ELEM_W'(~diff_u + 1'b1) : diff_u[ELEM_W-1:0];
        sq     = {{ELEM_W{1'b0}}, mag} * {{ELEM_W{1'b0}}, mag};
        term   = (mode == MODE_ABS) ? ACC_W'(mag) : ACC_W'(sq);
    end

endmodule

// File: rtl/dsq_vec.sv
// dsq_vec: multi-cycle PCPI distance-squared / abs-difference accumulator.
// One lane term is added per cycle through a single shared dsq_lane.
// Build option: define DSQ_VEC_SAT_EN for sticky saturating accumulation;
// otherwise sums wrap modulo 2^ACC_W.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a matching request; captures operands on accept
// BUSY    | adding one lane term per cycle; valid drop aborts to IDLE
// DONE    | ready/wr pulse; commits internal acc for SQACC/CLR
module dsq_vec
    import dsq_pkg::*;
#(
    parameter int ELEM_W = 8,
    parameter int LANES  = 2,
    parameter int ACC_W  = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic [31:0] instr,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        ready,
    output logic        wait_,
    output logic        wr,
    output logic [31:0] rd
);

    localparam int PAIR_W = 2 * ELEM_W;
    localparam int LCW    = (LANES > 1) ? $clog2(LANES) : 1;

    if (!cfg_ok(ELEM_W, LANES)) begin : g_cfg_check
        $error("dsq_vec: illegal ELEM_W/LANES combination");
    end

    logic [1:0]       state;
    logic [LCW-1:0]   lane_cnt;
    mode_e            mode_r;
    logic [31:0]      rs1_r;
    logic [ACC_W-1:0] sum_r;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] rd_r;
    logic             ready_r;

    mode_e            mode_in;
    logic             match;
    logic [PAIR_W-1:0] pair;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] next_sum;
    logic             last_lane;
    logic             unused_instr;

    // Request decode: opcode, funct7 and one of the four defined funct3 modes.
    always_comb begin
        mode_in = mode_e'(instr[14:12]);
        match   = (instr[6:0] == OPC_CUSTOM0) && (instr[31:25] == F7_DSQ) &&
                  (instr[14] == 1'b0);
        wait_   = valid && match && resetn && (state != ST_DONE);
    end

    assign unused_instr = ^{instr[24:15], instr[11:7]};

    // Select the current lane pair; lane 0 sits in the MSBs of rs1.
    always_comb begin
        pair = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_cnt == LCW'(i)) begin
                pair = rs1_r[(LANES-1-i)*PAIR_W +: PAIR_W];
            end
        end
        last_lane = (lane_cnt == LCW'(LANES - 1));
    end

    dsq_lane #(
        .ELEM_W (ELEM_W),
        .ACC_W  (ACC_W)
    ) u_lane (
        .x    (pair[PAIR_W-1:ELEM_W]),
        .xd   (pair[ELEM_W-1:0]),
        .mode (mode_r),
        .term (term)
    );

`ifdef DSQ_VEC_SAT_EN
    logic             sat_r;
    logic             next_sat;
    logic [ACC_W:0]   add_full;

    // Saturate on carry-out and hold all-ones for the rest of the operation.
    always_comb begin
        add_full = {1'b0, sum_r} + {1'b0, term};
        next_sat = sat_r || add_full[ACC_W];
        next_sum = next_sat ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
    end

    // Sticky saturation flag, cleared whenever a new request is accepted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sat_r <= 1'b0;
        end else if (state == ST_IDLE) begin
            sat_r <= 1'b0;
        end else if (state == ST_BUSY && valid) begin
            sat_r <= next_sat;
        end
    end
`else
    // Plain modular accumulation.
    always_comb begin
        next_sum = sum_r + term;
    end
`endif

    // Sequencer: capture, per-lane accumulate, result/commit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            lane_cnt <= '0;
            mode_r   <= MODE_SQ;
            rs1_r    <= '0;
            sum_r    <= '0;
            acc_r    <= '0;
            rd_r     <= '0;
            ready_r  <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid && match) begin
                        mode_r   <= mode_in;
                        rs1_r    <= rs1;
                        lane_cnt <= '0;
                        sum_r    <= (mode_in == MODE_SQACC) ? acc_r : ACC_W'(rs2);
                        if (mode_in == MODE_CLR) begin
                            rd_r    <= acc_r;
                            ready_r <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!valid) begin
                        state <= ST_IDLE;
                    end else begin
                        sum_r    <= next_sum;
                        lane_cnt <= lane_cnt + 1'b1;
                        if (last_lane) begin
                            rd_r    <= next_sum;
                            ready_r <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (mode_r == MODE_SQACC) begin
                        acc_r <= sum_r;
                    end else if (mode_r == MODE_CLR) begin
                        acc_r <= '0;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ready = ready_r;
    assign wr    = ready_r;
    assign rd    = rd_r[31:0];

endmodule

// File: tb/tb_dsq_vec.sv
// Scoreboard bench for dsq_vec: driver pushes expected results/timing,
// a negedge monitor pops and compares on every ready pulse.
module tb_dsq_vec;

    localparam int ELEM_W = 8;
    localparam int LANES  = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        ready, wait_, wr;
    logic [31:0] rd;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    longint acc_m = 0;

    typedef struct {
        logic [31:0] val;
        int          at;
    } exp_t;
    exp_t sb[$];

    dsq_vec #(.ELEM_W(ELEM_W), .LANES(LANES), .ACC_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .valid  (valid),
        .instr  (instr),
        .rs1    (rs1),
        .rs2    (rs2),
        .ready  (ready),
        .wait_  (wait_),
        .wr     (wr),
        .rd     (rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [6:0] f7);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0001011};
    endfunction

    // Reference: sum of per-lane terms in plain integer arithmetic.
    function automatic logic [31:0] ref_op(input int f3, input logic [31:0] a, input logic [31:0] b);
        longint total;
        int x, xd, d;
        int mask;
        mask = (1 << ELEM_W) - 1;
        if (f3 == 3) return acc_m[31:0];
        total = (f3 == 2) ? acc_m : longint'(b);
        for (int i = 0; i < LANES; i++) begin
            x  = int'(a >> (32 - (2*i+1)*ELEM_W)) & mask;
            xd = int'(a >> (32 - (2*i+2)*ELEM_W)) & mask;
            d  = x - xd;
            if (f3 == 1) total += (d < 0) ? -d : d;
            else         total += longint'(d) * longint'(d);
        end
`ifdef DSQ_VEC_SAT_EN
        if (total > 64'hFFFF_FFFF) total = 64'hFFFF_FFFF;
`else
        total = total & 64'hFFFF_FFFF;
`endif
        return total[31:0];
    endfunction

    // Issue one request, push its expectation, hold valid until ready.
    task automatic do_op(input int f3, input logic [31:0] a, input logic [31:0] b,
                         input bit use_exp, input logic [31:0] exp_v);
        exp_t e;
        logic [31:0] r;
        bit seen;
        @(negedge clk);
        valid = 1'b1;
        instr = mk_instr(3'(f3), 7'b0000001);
        rs1 = a;
        rs2 = b;
        r = use_exp ? exp_v : ref_op(f3, a, b);
        e.val = r;
        e.at  = cyc + ((f3 == 3) ? 1 : LANES + 1);
        sb.push_back(e);
        if (f3 == 2) acc_m = longint'(r);
        if (f3 == 3) acc_m = 0;
        #1 chk("wait_req", {31'd0, wait_}, 32'd1);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (ready) begin
                seen = 1'b1;
                chk("wait_done", {31'd0, wait_}, 32'd0);
            end else begin
                chk("wait_busy", {31'd0, wait_}, 32'd1);
            end
        end
        if (!seen) chk("ready_timeout", 32'd0, 32'd1);
        valid = 1'b0;
    endtask

    // Monitor: every ready pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ready || wr) begin
                chk("wr_eq_ready", {31'd0, wr}, {31'd0, ready});
                if (sb.size() == 0) begin
                    chk("unexpected_ready", {31'd0, ready}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rd", rd, e.val);
                    chk("latency", cyc, e.at);
                end
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        int f3;

        // Reset with a legal request on the bus: nothing may be claimed.
        valid = 1'b1;
        instr = mk_instr(3'b000, 7'b0000001);
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_wr", {31'd0, wr}, 32'd0);
        chk("rst_wait", {31'd0, wait_}, 32'd0);
        chk("rst_rd", rd, 32'd0);
        valid = 1'b0;
        resetn = 1'b1;

        do_op(0, {8'd10, 8'd7, 8'd5, 8'd3}, 32'd0, 1'b1, 32'd13);
        do_op(0, {8'd7, 8'd10, 8'd3, 8'd5}, 32'd0, 1'b1, 32'd13);
        do_op(1, {8'd7, 8'd10, 8'd3, 8'd5}, 32'd100, 1'b1, 32'd105);
        do_op(2, {8'd10, 8'd8, 8'd6, 8'd4}, 32'hDEAD_BEEF, 1'b1, 32'd8);
        do_op(2, {8'd3, 8'd1, 8'd9, 8'd6}, 32'd0, 1'b1, 32'd21);
        do_op(3, 32'd0, 32'd0, 1'b1, 32'd21);
        do_op(2, {8'd1, 8'd0, 8'd0, 8'd0}, 32'd0, 1'b1, 32'd1);
`ifdef DSQ_VEC_SAT_EN
        do_op(0, {8'd255, 8'd0, 8'd0, 8'd255}, 32'hFFFF_FFF0, 1'b1, 32'hFFFF_FFFF);
`else
        do_op(0, {8'd255, 8'd0, 8'd0, 8'd255}, 32'hFFFF_FFF0, 1'b1, 32'h0001_FBF2);
`endif
        chk("rd_hold", rd, sb.size() == 0 ? rd : 32'hX);

        // Abort an SQACC in its first BUSY cycle; acc must stay at 1.
        @(negedge clk);
        valid = 1'b1;
        instr = mk_instr(3'b010, 7'b0000001);
        rs1 = {8'd200, 8'd0, 8'd200, 8'd0};
        @(negedge clk);
        valid = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("abort_no_ready", {31'd0, ready}, 32'd0);
        end
        do_op(3, 32'd0, 32'd0, 1'b1, 32'd1);

        // Non-matching funct7, then reserved funct3.
        @(negedge clk);
        valid = 1'b1;
        instr = mk_instr(3'b000, 7'b0000010);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("bad_f7_wait", {31'd0, wait_}, 32'd0);
            chk("bad_f7_ready", {31'd0, ready}, 32'd0);
        end
        instr = mk_instr(3'b111, 7'b0000001);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("bad_f3_wait", {31'd0, wait_}, 32'd0);
            chk("bad_f3_ready", {31'd0, ready}, 32'd0);
        end
        valid = 1'b0;

        // Prime acc, then reset in the middle of an SQACC.
        do_op(2, {8'd9, 8'd0, 8'd0, 8'd0}, 32'd0, 1'b1, 32'd81);
        @(negedge clk);
        valid = 1'b1;
        instr = mk_instr(3'b010, 7'b0000001);
        rs1 = {8'd50, 8'd0, 8'd0, 8'd0};
        @(negedge clk);
        resetn = 1'b0;
        #1 chk("midrst_wait", {31'd0, wait_}, 32'd0);
        @(negedge clk);
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        chk("midrst_wr", {31'd0, wr}, 32'd0);
        chk("midrst_rd", rd, 32'd0);
        valid = 1'b0;
        resetn = 1'b1;
        acc_m = 0;
        do_op(3, 32'd0, 32'd0, 1'b1, 32'd0);

        // Randomized back-to-back traffic against the reference model.
        for (int k = 0; k < 60; k++) begin
            f3 = int'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? (32'hFFFF_0000 | $urandom) : $urandom;
            do_op(f3, ra, rb, 1'b0, 32'd0);
        end

        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends with a summary.
    initial begin
        #200000;
        chk("global_timeout", 32'd0, 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
